cnn_layer_sequencer: RTL
========================

# cnn_layer_sequencer

Top-level controller for the CNN inference datapath. Sequences one frame through convolution, pooling, flattening and fully-connected stages by issuing single-cycle start pulses and waiting on each stage's done signal. Watches every stage with a timeout, reports a sticky error, and counts completed frames. Sits between the host/frame-capture logic and the layer blocks.

## Interface
- TIMEOUT_CYCLES, 1024 — maximum cycles a stage may spend in its state without asserting done; must be ≥2.
- FRAME_CNT_W, 16 — width of the completed-frame counter.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- frame_start  in  1  request to process one frame; accepted only when ready=1
- ready  out  1  high only in IDLE
- busy  out  1  high in CONV, POOL, FLAT, FC, DONE
- conv_start  out  1  single-cycle start pulse to convolution
- conv_done  in  1  convolution finished
- pool_start  out  1  single-cycle start pulse to pooling
- pool_done  in  1  pooling finished
- flat_start  out  1  single-cycle start pulse to flattener
- flat_done  in  1  flattener finished; may be a combinational level
- fc_start  out  1  single-cycle start pulse to FC layer
- fc_done  in  1  FC layer finished
- stage  out  3  current state encoding
- frame_done  out  1  single-cycle pulse per completed frame
- frame_count  out  FRAME_CNT_W  completed frames; wraps modulo 2^FRAME_CNT_W
- error  out  1  sticky timeout flag
- err_stage  out  3  state encoding of the stage that timed out
- clear_err  in  1  leaves ERR and clears error

## Operation
- States and encodings: IDLE=0, CONV=1, POOL=2, FLAT=3, FC=4, DONE=5, ERR=6.
- IDLE: when frame_start=1, go to CONV.
- Stage handshakes:
  - CONV → POOL on conv_done.
  - POOL → FLAT on pool_done.
  - FLAT → FC on flat_done.
  - FC → DONE on fc_done.
- DONE lasts one cycle, then returns to IDLE. In that cycle frame_done=1 and frame_count increments.
- Start pulses are registered outputs. Each stage's start is high only during the first cycle in that stage state.
- Done sampling:
  - A stage's done input is sampled only in its own state, and only from the second cycle in that state onward.
  - Done during the start-pulse cycle is ignored.
  - Done inputs of non-current stages are always ignored.
- Watchdog:
  - The counter clears on stage entry and increments each cycle in the stage.
  - If the counter reaches TIMEOUT_CYCLES-1 with no valid done, the next state is ERR.
  - On ERR entry, error=1 and err_stage=the timed-out stage.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Timeout and valid done in the same cycle: done wins.
- ERR: remains until clear_err=1, then goes to IDLE. error and err_stage clear to 0 on that transition. frame_start in ERR is ignored.
- clear_err outside ERR is ignored.
- frame_start while ready=0 is dropped. There is no queuing.
- frame_count wrap: from all-ones it increments to 0 with no flag.

## Timing
- Reset values: ready=1, busy=0, all *_start=0, stage=0, frame_done=0, frame_count=0, error=0, err_stage=0, state=IDLE.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); any in-flight start pulse drops.
- State transitions take effect one cycle after the qualifying input.
- Minimum frame latency: frame_start at cycle 0 → conv_start at 1 → frame_done at 9, with each done at the earliest legal cycle (2, 4, 6, 8). ready returns at cycle 10.
- A stage that never completes holds its state for TIMEOUT_CYCLES cycles, counted from its start-pulse cycle; ERR follows on the next cycle.

## Structure
- Shared package cnn_pkg holds:
  - typedef seq_state_t: 3-bit enum with the encodings above.
  - Constant SEQ_STATE_W=3.
- Sub-module stage_watchdog, parameterized by TIMEOUT_CYCLES:
  - Inputs: clk, reset, clear, enable.
  - Output: expired.
- The sequencer FSM, start-pulse registers, error registers and frame counter live in cnn_layer_sequencer.

## Test plan
- Nominal frame: frame_start at cycle 0; each done asserted one cycle after its start → start pulses at cycles 1/3/5/7, frame_done at 9, frame_count=1, ready at 10.
- Stray and early done:
  - pool_done held high during CONV → ignored.
  - conv_done asserted only in the conv_start cycle → ignored; conv_done one cycle later advances the FSM.
- Timeout with TIMEOUT_CYCLES=8: flat_done never asserts → ERR at 8 cycles after flat_start, error=1, err_stage=3. Then:
  - frame_start in ERR is ignored.
  - clear_err → IDLE, error=0.
- Timeout/done race: fc_done in the same cycle the watchdog expires → DONE, error stays 0.
- Reset mid-FC: all outputs return to reset values immediately; next frame_start runs a clean frame; frame_count counts only frames completed after reset.
- Wrap with FRAME_CNT_W=2: four nominal frames → frame_count sequence 1, 2, 3, 0; frame_start during busy is dropped and no extra frame occurs.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer.
package cnn_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    // Encodings are visible on the stage/err_stage outputs, so keep them fixed.
    typedef enum logic [SEQ_STATE_W-1:0] {
        StIdle = 3'd0,
        StConv = 3'd1,
        StPool = 3'd2,
        StFlat = 3'd3,
        StFc   = 3'd4,
        StDone = 3'd5,
        StErr  = 3'd6
    } seq_state_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage timeout counter: cleared on stage entry, counts while a stage is active,
// flags expiry once it has seen TIMEOUT_CYCLES cycles in the stage.
module stage_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Expiry is only meaningful while a stage is being watched.
    assign expired_o = enable_i && (cnt_q == CntMax);

    // Clear dominates; saturate at the terminal count so it never wraps back.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame sequencer: walks one frame through conv, pool, flatten and FC stages with
// registered start pulses, per-stage timeout, sticky error and a frame counter.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   conv_start_o,
    input  logic                   conv_done_i,
    output logic                   pool_start_o,
    input  logic                   pool_done_i,
    output logic                   flat_start_o,
    input  logic                   flat_done_i,
    output logic                   fc_start_o,
    input  logic                   fc_done_i,
    output logic [SEQ_STATE_W-1:0] stage_o,
    output logic                   frame_done_o,
    output logic [FRAME_CNT_W-1:0] frame_count_o,
    output logic                   error_o,
    output logic [SEQ_STATE_W-1:0] err_stage_o,
    input  logic                   clear_err_i
);

    seq_state_t state_q, state_d;
    logic [3:0] start_q, start_d;  // [0]=conv [1]=pool [2]=flat [3]=fc
    logic error_q, error_d;
    logic [SEQ_STATE_W-1:0] err_stage_q, err_stage_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic wd_clear, wd_enable, wd_expired;
    logic conv_ok, pool_ok, flat_ok, fc_ok;

    // A done is only honoured after the start-pulse cycle of its own stage.
    assign conv_ok = conv_done_i && !start_q[0];
    assign pool_ok = pool_done_i && !start_q[1];
    assign flat_ok = flat_done_i && !start_q[2];
    assign fc_ok   = fc_done_i   && !start_q[3];

    assign wd_enable = (state_q == StConv) || (state_q == StPool) ||
                       (state_q == StFlat) || (state_q == StFc);
    assign wd_clear  = (state_d != state_q);

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );

    // Next-state logic; a valid done beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (frame_start_i) state_d = StConv;
            StConv: if (conv_ok) state_d = StPool; else if (wd_expired) state_d = StErr;
            StPool: if (pool_ok) state_d = StFlat; else if (wd_expired) state_d = StErr;
            StFlat: if (flat_ok) state_d = StFc;   else if (wd_expired) state_d = StErr;
            StFc:   if (fc_ok)   state_d = StDone; else if (wd_expired) state_d = StErr;
            StDone: state_d = StIdle;
            StErr:  if (clear_err_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Start pulses fire on the cycle a stage is entered.
    always_comb begin
        start_d = 4'b0000;
        if (state_d != state_q) begin
            unique case (state_d)
                StConv:  start_d[0] = 1'b1;
                StPool:  start_d[1] = 1'b1;
                StFlat:  start_d[2] = 1'b1;
                StFc:    start_d[3] = 1'b1;
                default: start_d = 4'b0000;
            endcase
        end
    end

    // Sticky error capture on ERR entry, cleared only when leaving ERR; frame counter.
    always_comb begin
        error_d     = error_q;
        err_stage_d = err_stage_q;
        frame_cnt_d = frame_cnt_q;
        if ((state_d == StErr) && (state_q != StErr)) begin
            error_d     = 1'b1;
            err_stage_d = state_q;
        end else if ((state_q == StErr) && clear_err_i) begin
            error_d     = 1'b0;
            err_stage_d = '0;
        end
        if (state_q == StDone) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            start_q     <= 4'b0000;
            error_q     <= 1'b0;
            err_stage_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ready_o       = (state_q == StIdle);
    assign busy_o        = wd_enable || (state_q == StDone);
    assign conv_start_o  = start_q[0];
    assign pool_start_o  = start_q[1];
    assign flat_start_o  = start_q[2];
    assign fc_start_o    = start_q[3];
    assign stage_o       = state_q;
    assign frame_done_o  = (state_q == StDone);
    assign frame_count_o = frame_cnt_q;
    assign error_o       = error_q;
    assign err_stage_o   = err_stage_q;

endmodule
